// File: rtl/frog_motion_controller.sv
// Frog game-state stage: synchronizes buttons, then on each frame_tick applies hops, collisions, lives, score and respawn.
// Optional build macro FROG_WRAP_EN: horizontal hops that leave the screen wrap to the opposite edge.
module frog_motion_controller #(
  parameter int H_DISPLAY       = 640,
  parameter int V_DISPLAY       = 480,
  parameter int FROG_SIZE       = 32,
  parameter int CAR_SIZE        = 32,
  parameter int STEP            = 32,
  parameter int START_X         = 304,
  parameter int START_Y         = 448,
  parameter int LIVES_INIT      = 3,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int RESPAWN_FRAMES  = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       frame_tick,
  input  logic [9:0] car_x,
  input  logic [9:0] car_y,
  output logic [9:0] frog_x,
  output logic [9:0] frog_y,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic       hit,
  output logic       game_over
);

  typedef enum logic [1:0] {ST_PLAY = 2'd0, ST_DEAD = 2'd1, ST_OVER = 2'd2} state_t;
  // Lower encoding = higher priority among real moves.
  typedef enum logic [2:0] {MV_NONE = 3'd0, MV_UP = 3'd1, MV_DOWN = 3'd2, MV_LEFT = 3'd3, MV_RIGHT = 3'd4} move_t;

  localparam logic [9:0]  START_X_C   = 10'(START_X);
  localparam logic [9:0]  START_Y_C   = 10'(START_Y);
  localparam logic [9:0]  STEP_C      = 10'(STEP);
  localparam logic [9:0]  X_MAX_C     = 10'(H_DISPLAY - FROG_SIZE);
  localparam logic [9:0]  Y_MAX_C     = 10'(V_DISPLAY - FROG_SIZE);
  localparam logic [10:0] FROG_SIZE_C = 11'(FROG_SIZE);
  localparam logic [10:0] CAR_SIZE_C  = 11'(CAR_SIZE);
  localparam logic [7:0]  COOLDOWN_C  = 8'(COOLDOWN_FRAMES);
  localparam logic [7:0]  RESPAWN_C   = 8'(RESPAWN_FRAMES);
  localparam logic [1:0]  LIVES_C     = 2'(LIVES_INIT);

  // Button vectors ordered {up, down, left, right}.
  logic [3:0] sync1_r, sync2_r, prev_r, rise_s;
  move_t      pending_r, edge_move_s;

  state_t     state_r, state_nxt_s;
  logic [9:0] frog_x_r, frog_x_nxt_s, frog_y_r, frog_y_nxt_s;
  logic [1:0] lives_r, lives_nxt_s;
  logic [7:0] score_r, score_nxt_s;
  logic [7:0] cooldown_r, cooldown_nxt_s;
  logic [7:0] timer_r, timer_nxt_s;
  logic       goal_r, goal_nxt_s;
  logic       hit_r, hit_nxt_s;
  logic       over_r;

  logic       hop_ok_s;
  logic [9:0] hop_x_s, hop_y_s;
  logic       collide_s;

  // Two-flop synchronizer plus previous-sample register for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
      prev_r  <= 4'b0000;
    end else begin
      sync1_r <= {btn_up, btn_down, btn_left, btn_right};
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign rise_s = sync2_r & ~prev_r;

  // Highest-priority rising edge seen this cycle.
  always_comb begin
    edge_move_s = MV_NONE;
    if (rise_s[3]) begin
      edge_move_s = MV_UP;
    end else if (rise_s[2]) begin
      edge_move_s = MV_DOWN;
    end else if (rise_s[1]) begin
      edge_move_s = MV_LEFT;
    end else if (rise_s[0]) begin
      edge_move_s = MV_RIGHT;
    end else begin
      edge_move_s = MV_NONE;
    end
  end

  // Pending move: cleared by every tick, only replaced by a higher-priority edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= MV_NONE;
    end else if (frame_tick) begin
      pending_r <= MV_NONE;
    end else if (edge_move_s != MV_NONE && (pending_r == MV_NONE || edge_move_s < pending_r)) begin
      pending_r <= edge_move_s;
    end else begin
      pending_r <= pending_r;
    end
  end

  // Candidate hop target and whether it is legal.
  always_comb begin
    hop_ok_s = 1'b0;
    hop_x_s  = frog_x_r;
    hop_y_s  = frog_y_r;
    case (pending_r)
      MV_UP: begin
        if (frog_y_r >= STEP_C) begin
          hop_ok_s = 1'b1;
          hop_y_s  = frog_y_r - STEP_C;
        end else begin
          hop_ok_s = 1'b0;
        end
      end
      MV_DOWN: begin
        if (({1'b0, frog_y_r} + {1'b0, STEP_C}) <= {1'b0, Y_MAX_C}) begin
          hop_ok_s = 1'b1;
          hop_y_s  = frog_y_r + STEP_C;
        end else begin
          hop_ok_s = 1'b0;
        end
      end
      MV_LEFT: begin
        if (frog_x_r >= STEP_C) begin
          hop_ok_s = 1'b1;
          hop_x_s  = frog_x_r - STEP_C;
        end else begin
`ifdef FROG_WRAP_EN
          hop_ok_s = 1'b1;
          hop_x_s  = X_MAX_C;
`else
          hop_ok_s = 1'b0;
`endif
        end
      end
      MV_RIGHT: begin
        if (({1'b0, frog_x_r} + {1'b0, STEP_C}) <= {1'b0, X_MAX_C}) begin
          hop_ok_s = 1'b1;
          hop_x_s  = frog_x_r + STEP_C;
        end else begin
`ifdef FROG_WRAP_EN
          hop_ok_s = 1'b1;
          hop_x_s  = 10'd0;
`else
          hop_ok_s = 1'b0;
`endif
        end
      end
      default: begin
        hop_ok_s = 1'b0;
      end
    endcase
  end

  // Box overlap using 11-bit sums so edges near 1023 cannot wrap.
  assign collide_s = ({1'b0, car_x} < ({1'b0, frog_x_r} + FROG_SIZE_C)) &&
                     ({1'b0, frog_x_r} < ({1'b0, car_x} + CAR_SIZE_C)) &&
                     ({1'b0, car_y} < ({1'b0, frog_y_r} + FROG_SIZE_C)) &&
                     ({1'b0, frog_y_r} < ({1'b0, car_y} + CAR_SIZE_C));

  // Per-frame game update; everything holds between ticks.
  always_comb begin
    state_nxt_s    = state_r;
    frog_x_nxt_s   = frog_x_r;
    frog_y_nxt_s   = frog_y_r;
    lives_nxt_s    = lives_r;
    score_nxt_s    = score_r;
    cooldown_nxt_s = cooldown_r;
    timer_nxt_s    = timer_r;
    goal_nxt_s     = goal_r;
    hit_nxt_s      = 1'b0;
    if (frame_tick) begin
      case (state_r)
        ST_PLAY: begin
          if (collide_s) begin
            hit_nxt_s   = 1'b1;
            lives_nxt_s = lives_r - 2'd1;
            goal_nxt_s  = 1'b0;
            if (lives_r == 2'd1) begin
              state_nxt_s = ST_OVER;
            end else begin
              state_nxt_s = ST_DEAD;
              timer_nxt_s = RESPAWN_C;
            end
          end else if (goal_r) begin
            frog_x_nxt_s = START_X_C;
            frog_y_nxt_s = START_Y_C;
            goal_nxt_s   = 1'b0;
            if (cooldown_r != 8'd0) begin
              cooldown_nxt_s = cooldown_r - 8'd1;
            end else begin
              cooldown_nxt_s = 8'd0;
            end
          end else if (pending_r != MV_NONE && cooldown_r == 8'd0) begin
            if (hop_ok_s) begin
              frog_x_nxt_s   = hop_x_s;
              frog_y_nxt_s   = hop_y_s;
              cooldown_nxt_s = COOLDOWN_C;
              if (hop_y_s == 10'd0) begin
                goal_nxt_s  = 1'b1;
                score_nxt_s = (score_r == 8'hFF) ? score_r : score_r + 8'd1;
              end else begin
                goal_nxt_s = 1'b0;
              end
            end else begin
              cooldown_nxt_s = cooldown_r;
            end
          end else if (cooldown_r != 8'd0) begin
            cooldown_nxt_s = cooldown_r - 8'd1;
          end else begin
            cooldown_nxt_s = cooldown_r;
          end
        end
        ST_DEAD: begin
          if (timer_r <= 8'd1) begin
            timer_nxt_s    = 8'd0;
            frog_x_nxt_s   = START_X_C;
            frog_y_nxt_s   = START_Y_C;
            cooldown_nxt_s = 8'd0;
            state_nxt_s    = ST_PLAY;
          end else begin
            timer_nxt_s = timer_r - 8'd1;
          end
        end
        ST_OVER: begin
          if (pending_r != MV_NONE) begin
            lives_nxt_s    = LIVES_C;
            score_nxt_s    = 8'd0;
            frog_x_nxt_s   = START_X_C;
            frog_y_nxt_s   = START_Y_C;
            cooldown_nxt_s = 8'd0;
            goal_nxt_s     = 1'b0;
            state_nxt_s    = ST_PLAY;
          end else begin
            state_nxt_s = ST_OVER;
          end
        end
        default: begin
          state_nxt_s = ST_PLAY;
        end
      endcase
    end else begin
      hit_nxt_s = 1'b0;
    end
  end

  // Game state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_PLAY;
      frog_x_r   <= START_X_C;
      frog_y_r   <= START_Y_C;
      lives_r    <= LIVES_C;
      score_r    <= 8'd0;
      cooldown_r <= 8'd0;
      timer_r    <= 8'd0;
      goal_r     <= 1'b0;
      hit_r      <= 1'b0;
      over_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      frog_x_r   <= frog_x_nxt_s;
      frog_y_r   <= frog_y_nxt_s;
      lives_r    <= lives_nxt_s;
      score_r    <= score_nxt_s;
      cooldown_r <= cooldown_nxt_s;
      timer_r    <= timer_nxt_s;
      goal_r     <= goal_nxt_s;
      hit_r      <= hit_nxt_s;
      over_r     <= (state_nxt_s == ST_OVER);
    end
  end

  assign frog_x    = frog_x_r;
  assign frog_y    = frog_y_r;
  assign lives     = lives_r;
  assign score     = score_r;
  assign hit       = hit_r;
  assign game_over = over_r;

endmodule

// File: tb/tb_frog_motion_controller.sv
// Scoreboard bench for frog_motion_controller: a frame-level game model predicts outputs after each tick.
module tb_frog_motion_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_up, btn_down, btn_left, btn_right, frame_tick;
  logic [9:0] car_x, car_y;
  logic [9:0] frog_x, frog_y;
  logic [1:0] lives;
  logic [7:0] score;
  logic       hit, game_over;

  logic       s_btn_up, s_tick;
  logic [9:0] s_frog_x, s_frog_y;
  logic [1:0] s_lives;
  logic [7:0] s_score;
  logic       s_hit, s_game_over;

  always #5 clk = ~clk;

  frog_motion_controller dut (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right), .frame_tick(frame_tick),
    .car_x(car_x), .car_y(car_y), .frog_x(frog_x), .frog_y(frog_y),
    .lives(lives), .score(score), .hit(hit), .game_over(game_over)
  );

  // Short-field instance: one hop from start reaches the goal, so score saturation is reachable quickly.
  frog_motion_controller #(.V_DISPLAY(64), .START_Y(32), .COOLDOWN_FRAMES(0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .btn_up(s_btn_up), .btn_down(1'b0),
    .btn_left(1'b0), .btn_right(1'b0), .frame_tick(s_tick),
    .car_x(10'd600), .car_y(10'd400), .frog_x(s_frog_x), .frog_y(s_frog_y),
    .lives(s_lives), .score(s_score), .hit(s_hit), .game_over(s_game_over)
  );

`ifdef FROG_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef struct {
    int x; int y; int lives; int score; int hit; int over;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model of the game, in frame-level integer terms.
  int m_x, m_y, m_lives, m_score, m_mode, m_cool, m_timer;
  bit m_goal;
  localparam int PLAY = 0, DEAD = 1, OVER = 2;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int move_of(input logic [3:0] b);
    if (b[3]) return 1;
    if (b[2]) return 2;
    if (b[1]) return 3;
    if (b[0]) return 4;
    return 0;
  endfunction

  function automatic void model_reset();
    m_x = 304; m_y = 448; m_lives = 3; m_score = 0;
    m_mode = PLAY; m_cool = 0; m_timer = 0; m_goal = 0;
  endfunction

  function automatic void model_tick(input int mv, input int cx, input int cy);
    exp_t e;
    int nx, ny;
    bit ok, hitv;
    hitv = 0;
    if (m_mode == PLAY) begin
      if (cx < m_x + 32 && m_x < cx + 32 && cy < m_y + 32 && m_y < cy + 32) begin
        hitv = 1; m_lives--; m_goal = 0;
        if (m_lives == 0) m_mode = OVER;
        else begin m_mode = DEAD; m_timer = 60; end
      end else if (m_goal) begin
        m_x = 304; m_y = 448; m_goal = 0;
        if (m_cool > 0) m_cool--;
      end else if (mv != 0 && m_cool == 0) begin
        nx = m_x; ny = m_y; ok = 1;
        case (mv)
          1: ny -= 32;
          2: ny += 32;
          3: nx -= 32;
          default: nx += 32;
        endcase
        if (nx < 0 || nx > 608) begin
          if (WRAP) nx = (nx < 0) ? 608 : 0;
          else ok = 0;
        end
        if (ny < 0 || ny > 448) ok = 0;
        if (ok) begin
          m_x = nx; m_y = ny; m_cool = 8;
          if (ny == 0) begin
            m_goal = 1;
            if (m_score < 255) m_score++;
          end
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end
    end else if (m_mode == DEAD) begin
      m_timer--;
      if (m_timer == 0) begin
        m_mode = PLAY; m_x = 304; m_y = 448; m_cool = 0;
      end
    end else if (mv != 0) begin
      m_lives = 3; m_score = 0; m_x = 304; m_y = 448;
      m_cool = 0; m_goal = 0; m_mode = PLAY;
    end
    e.x = m_x; e.y = m_y; e.lives = m_lives; e.score = m_score;
    e.hit = hitv; e.over = (m_mode == OVER);
    sb.push_back(e);
  endfunction

  // Press the given buttons, present the car, then issue one frame tick.
  task automatic do_frame(input logic [3:0] btns, input int cx, input int cy);
    @(negedge clk);
    {btn_up, btn_down, btn_left, btn_right} = btns;
    car_x = 10'(cx); car_y = 10'(cy);
    repeat (2) @(negedge clk);
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    repeat (3) @(negedge clk);
    model_tick(move_of(btns), cx & 1023, cy & 1023);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check({tag, "_x"}, frog_x, 304);
    check({tag, "_y"}, frog_y, 448);
    check({tag, "_lives"}, lives, 3);
    check({tag, "_score"}, score, 0);
    check({tag, "_hit"}, hit, 0);
    check({tag, "_over"}, game_over, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic sat_goal(input int g);
    @(negedge clk); s_btn_up = 1'b1;
    repeat (2) @(negedge clk); s_btn_up = 1'b0;
    repeat (3) @(negedge clk); s_tick = 1'b1;
    @(negedge clk); s_tick = 1'b0;
    check("sat_goal_y", s_frog_y, 0);
    check("sat_score", s_score, (g + 1 > 255) ? 255 : g + 1);
    @(negedge clk); s_tick = 1'b1;
    @(negedge clk); s_tick = 1'b0;
    check("sat_return_y", s_frog_y, 32);
  endtask

  // Monitor: after each tick, pop the prediction and compare; one cycle later hit must be gone.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (frame_tick === 1'b1 && rst_n === 1'b1) begin
        @(negedge clk);
        if (sb.size() == 0) begin
          check("scoreboard_empty", 1, 0);
        end else begin
          e = sb.pop_front();
          check("frog_x", frog_x, e.x);
          check("frog_y", frog_y, e.y);
          check("lives", lives, e.lives);
          check("score", score, e.score);
          check("hit", hit, e.hit);
          check("game_over", game_over, e.over);
          @(negedge clk);
          check("hit_one_cycle", hit, 0);
          check("hold_y", frog_y, e.y);
        end
      end
    end
  end

  initial begin
    int cx, cy;
    logic [3:0] b;
    rst_n = 1'b0; frame_tick = 1'b0;
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    s_btn_up = 1'b0; s_tick = 1'b0;
    car_x = 10'd0; car_y = 10'd0;
    model_reset();
    repeat (3) @(negedge clk);
    do_reset("reset");

    // Hop up, second press dropped during cooldown, then hop again.
    do_frame(4'b1000, 0, 0);
    do_frame(4'b1000, 0, 0);
    for (int i = 0; i < 7; i++) do_frame(4'b0000, 0, 0);
    do_frame(4'b1000, 0, 0);

    // Up and left together: up wins.
    do_reset("reset2");
    do_frame(4'b1010, 0, 0);

    // Car touching but not overlapping, then overlapping; death and respawn.
    do_reset("reset3");
    do_frame(4'b1000, 304, 416);
    do_frame(4'b0000, 304, 416);
    for (int i = 0; i < 61; i++) do_frame(4'b0000, 0, 0);

    // Lose all lives, stay over, then restart with a press.
    do_reset("reset4");
    for (int i = 0; i < 200 && m_mode != OVER; i++) do_frame(4'b0000, 304, 448);
    do_frame(4'b0000, 304, 448);
    do_frame(4'b0000, 304, 448);
    do_frame(4'b0100, 0, 0);
    do_frame(4'b0000, 0, 0);

    // Climb to the goal and return to start.
    do_reset("reset5");
    for (int i = 0; i < 20 && !m_goal; i++) begin
      do_frame(4'b1000, 0, 0);
      for (int k = 0; k < 8; k++) do_frame(4'b0000, 0, 0);
    end
    do_frame(4'b0000, 0, 0);

    // March left into the edge, then right across the other edge.
    do_reset("reset6");
    for (int i = 0; i < 12; i++) begin
      do_frame(4'b0010, 0, 0);
      for (int k = 0; k < 8; k++) do_frame(4'b0000, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      do_frame(4'b0001, 0, 0);
      for (int k = 0; k < 8; k++) do_frame(4'b0000, 0, 0);
    end

    // Reset during cooldown; the next press must hop immediately.
    do_frame(4'b1000, 0, 0);
    do_reset("reset_mid");
    do_frame(4'b1000, 0, 0);

    // Randomized play.
    for (int i = 0; i < 400; i++) begin
      b = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      if ($urandom_range(0, 9) == 0) begin
        cx = m_x + $urandom_range(0, 80) - 40;
        cy = m_y + $urandom_range(0, 80) - 40;
        if (cx < 0) cx = 0;
        if (cy < 0) cy = 0;
      end else begin
        cx = 32 * $urandom_range(0, 19);
        cy = 32 * $urandom_range(0, 14);
      end
      do_frame(b, cx, cy);
    end

    // Score saturation on the short-field instance.
    for (int g = 0; g < 257; g++) sat_goal(g);
    check("sat_lives", s_lives, 3);
    check("sat_over", s_game_over, 0);
    check("sat_hit", s_hit, 0);
    check("sat_x", s_frog_x, 304);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
